genesis_pad_scanner: RTL and testbench
======================================

// Module: genesis_pad_scanner
// PURPOSE
//  Multi-pad Sega Genesis controller scanner on the system clock; the frame clock only paces scans.
//  - On each frame_tick it drives the select line per pad, waits a settle time and samples both mux phases.
//  - Publishes active-high button words, plus per-button press and release events.
//  - Sits between the pad pins and the CPU/MMIO input registers.
// PARAMETERS
//  NUM_PADS       2    number of pads scanned in parallel (1..4)
//  SETTLE_CYCLES  64   clk cycles select is held before sampling (>=2)
//  CNT_W          8    settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clk        in   1            system clock
//  clr        in   1            synchronous active-high reset
//  en         in   1            scan enable; frame_tick ignored when low
//  frame_tick in   1            1-cycle strobe, starts a scan
//  pin0..pin3 in   NUM_PADS     Up/Down/Left/Right (raw, active-low), bit p = pad p
//  pin5, pin8 in   NUM_PADS     B/A, C/Start (raw, active-low)
//  pin6       out  NUM_PADS     select to each pad, all pads driven identically
//  buttons    out  BTN_W*NUM_PADS  pad p at [p*BTN_W +: BTN_W]
//                               low byte {Start,C,B,A,Right,Left,Down,Up}; 1 = pressed
//  pressed    out  BTN_W*NUM_PADS  1-cycle: bit went 0->1 versus the previous scan
//  released   out  BTN_W*NUM_PADS  1-cycle: bit went 1->0 versus the previous scan
//  valid      out  1            1-cycle strobe; buttons, pressed and released updated together
//  busy       out  1            high while a scan is in progress
//  overrun    out  1            sticky; set by a frame_tick that arrives while busy; cleared by clr
// BEHAVIOUR
//  - Reset (clr): state IDLE, pin6 all 1, counter 0; buttons, pressed, released, valid, busy, overrun all 0.
//  - clr mid-scan aborts the scan. No partial update reaches buttons.
//  - BTN_W = 8, or 12 with GENESIS_6BTN_EN.
//  - FSM: IDLE -> WAIT_H -> WAIT_L -> COMMIT -> IDLE.
//  - IDLE: pin6 = 1. When frame_tick & en: load counter SETTLE_CYCLES-1, go to WAIT_H.
//  - WAIT_H: pin6 = 1. Counter decrements each cycle.
//    - At 0, latch ~pin0, ~pin1, ~pin2, ~pin3, ~pin5 (B) and ~pin8 (C) into a shadow register.
//    - Then reload the counter and go to WAIT_L.
//  - WAIT_L: pin6 = 0. At 0, latch ~pin5 (A) and ~pin8 (Start), then go to COMMIT.
//    Up/Down are not resampled in this phase.
//  - COMMIT: buttons <= shadow; pressed <= shadow & ~buttons; released <= ~shadow & buttons.
//    valid <= 1 for exactly one cycle; pin6 <= 1; go to IDLE.
//  - pressed and released are 0 in every cycle where valid is 0.
//  - busy = (state != IDLE).
//  - Latency: valid is high 2*SETTLE_CYCLES+2 cycles after the cycle in which frame_tick is sampled.
//  - frame_tick while busy: ignored, overrun <= 1, current scan unaffected.
//  - frame_tick in the same cycle as COMMIT is also counted as overrun.
//  - en dropping mid-scan: the scan completes. Only new scans are gated.
//  - Pads are sampled on the same edge; there is no per-pad skew.
//  - Pins are asynchronous. Each pin passes through a 2-flop synchroniser before sampling;
//    this is included in the settle time.
// CONFIGURATION
//  GENESIS_6BTN_EN undefined:
//    - 3-button pads only, BTN_W = 8, FSM exactly as above.
//  GENESIS_6BTN_EN defined:
//    - BTN_W = 12; bits [11:8] = {Mode,X,Y,Z}.
//    - FSM runs select phases H1 L1 H2 L2 H3 L3 H4, each SETTLE_CYCLES long, then COMMIT.
//    - H1 and L1 sample as WAIT_H/WAIT_L.
//    - L3: pad is 6-button iff pin0 & pin1 both low (raw).
//    - H4: if 6-button, latch Z=~pin0, Y=~pin1, X=~pin2, Mode=~pin3; otherwise bits [11:8] = 0.
//    - Latency 7*SETTLE_CYCLES+2.
// TESTING
//  (SETTLE_CYCLES=4, NUM_PADS=2 unless noted)
//  1 Reset value: clr held 3 cycles mid-WAIT_L -> pin6=2'b11, buttons=0, busy=0, no valid for 20 cycles.
//  2 One scan: pad0 holds Up and A low, pad1 idle, single frame_tick.
//    -> valid at cycle +10; buttons=16'h0011; pressed=16'h0011; pin6 high/low phases of 4 cycles each.
//  3 Release event: next scan with pad0 all high -> buttons=0, released=16'h0011, pressed=0.
//  4 Overrun: second frame_tick 3 cycles after the first -> one valid only, overrun=1 until clr.
//  5 Start vs C mux: pad1 pin8 low only while pin6=0 -> pad1 Start (bit 15) set, C (bit 14) clear.
//  6 GENESIS_6BTN_EN: pad0 model pulls pin0/pin1 low in L3 and pin2 low in H4.
//    -> buttons[11:8]=4'b0100 (X); pad1 3-button model -> [23:20]=0; valid at +30.

Source files
------------

// File: rtl/genesis_pad_scanner_if.sv
// Pad-pin and register-side bundle for genesis_pad_scanner.
// BTN_W defaults to 12 when GENESIS_6BTN_EN is defined, otherwise 8.
interface genesis_pad_scanner_if #(
    parameter int NUM_PADS = 2,
`ifdef GENESIS_6BTN_EN
    parameter int BTN_W    = 12
`else
    parameter int BTN_W    = 8
`endif
);
    logic                      en;
    logic                      frame_tick;
    logic [NUM_PADS-1:0]       pin0;
    logic [NUM_PADS-1:0]       pin1;
    logic [NUM_PADS-1:0]       pin2;
    logic [NUM_PADS-1:0]       pin3;
    logic [NUM_PADS-1:0]       pin5;
    logic [NUM_PADS-1:0]       pin8;
    logic [NUM_PADS-1:0]       pin6;
    logic [BTN_W*NUM_PADS-1:0] buttons;
    logic [BTN_W*NUM_PADS-1:0] pressed;
    logic [BTN_W*NUM_PADS-1:0] released;
    logic                      valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output en, frame_tick, pin0, pin1, pin2, pin3, pin5, pin8,
        input  pin6, buttons, pressed, released, valid, busy, overrun
    );

    modport slave (
        input  en, frame_tick, pin0, pin1, pin2, pin3, pin5, pin8,
        output pin6, buttons, pressed, released, valid, busy, overrun
    );
endinterface

// File: rtl/genesis_pad_scanner.sv
// Multi-pad Sega Genesis scanner: each frame_tick walks the select phases and publishes
// button words with press/release events. Define GENESIS_6BTN_EN for 6-button pad support.
module genesis_pad_scanner #(
    parameter int NUM_PADS      = 2,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    genesis_pad_scanner_if.slave bus
);

`ifdef GENESIS_6BTN_EN
    localparam int BTN_W = 12;
    typedef enum logic [3:0] {
        S_IDLE, S_H1, S_L1, S_H2, S_L2, S_H3, S_L3, S_H4, S_COMMIT
    } state_t;
    localparam state_t S_SAMPLE_H = S_H1;
    localparam state_t S_SAMPLE_L = S_L1;
`else
    localparam int BTN_W = 8;
    typedef enum logic [1:0] {
        S_IDLE, S_WAIT_H, S_WAIT_L, S_COMMIT
    } state_t;
    localparam state_t S_SAMPLE_H = S_WAIT_H;
    localparam state_t S_SAMPLE_L = S_WAIT_L;
`endif

    localparam int               W      = BTN_W * NUM_PADS;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [6*NUM_PADS-1:0] sync1_q, sync1_d;
    logic [6*NUM_PADS-1:0] sync2_q, sync2_d;
    logic [W-1:0]          shadow_q, shadow_d;
    logic [W-1:0]          buttons_q, buttons_d;
    logic [W-1:0]          pressed_q, pressed_d;
    logic [W-1:0]          released_q, released_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic [NUM_PADS-1:0]   pin6_q, pin6_d;
    logic                  sel_low_d;
    logic                  busy;
`ifdef GENESIS_6BTN_EN
    logic [NUM_PADS-1:0]   six_q, six_d;
`endif

    logic [NUM_PADS-1:0] s_pin0, s_pin1, s_pin2, s_pin3, s_pin5, s_pin8;

    // Two-flop synchroniser on every raw pin; its delay is absorbed by the settle time.
    always_comb begin
        sync1_d = {bus.pin8, bus.pin5, bus.pin3, bus.pin2, bus.pin1, bus.pin0};
        sync2_d = sync1_q;
    end

    assign {s_pin8, s_pin5, s_pin3, s_pin2, s_pin1, s_pin0} = sync2_q;
    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        buttons_d  = buttons_q;
        pressed_d  = '0;
        released_d = '0;
        valid_d    = 1'b0;
        overrun_d  = overrun_q | (bus.frame_tick & busy);
`ifdef GENESIS_6BTN_EN
        six_d      = six_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.frame_tick && bus.en) begin
                    state_d = S_SAMPLE_H;
                    cnt_d   = RELOAD;
                end
            end
            S_COMMIT: begin
                buttons_d  = shadow_q;
                pressed_d  = shadow_q & ~buttons_q;
                released_d = ~shadow_q & buttons_q;
                valid_d    = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Phases are declared in scan order, so the next phase is the next encoding.
                    cnt_d   = RELOAD;
                    state_d = state_t'(state_q + 1'b1);
                    for (int p = 0; p < NUM_PADS; p++) begin
                        if (state_q == S_SAMPLE_H) begin
                            shadow_d[p*BTN_W + 0] = ~s_pin0[p];
                            shadow_d[p*BTN_W + 1] = ~s_pin1[p];
                            shadow_d[p*BTN_W + 2] = ~s_pin2[p];
                            shadow_d[p*BTN_W + 3] = ~s_pin3[p];
                            shadow_d[p*BTN_W + 5] = ~s_pin5[p];
                            shadow_d[p*BTN_W + 6] = ~s_pin8[p];
                        end
                        if (state_q == S_SAMPLE_L) begin
                            shadow_d[p*BTN_W + 4] = ~s_pin5[p];
                            shadow_d[p*BTN_W + 7] = ~s_pin8[p];
                        end
`ifdef GENESIS_6BTN_EN
                        if (state_q == S_L3) begin
                            six_d[p] = ~s_pin0[p] & ~s_pin1[p];
                        end
                        if (state_q == S_H4) begin
                            shadow_d[p*BTN_W + 8 +: 4] = six_q[p] ?
                                ~{s_pin3[p], s_pin2[p], s_pin1[p], s_pin0[p]} : 4'b0000;
                        end
`endif
                    end
                end
            end
        endcase

        // Select is registered from the next state so the pad sees a clean, glitch-free level.
`ifdef GENESIS_6BTN_EN
        sel_low_d = (state_d == S_L1) || (state_d == S_L2) || (state_d == S_L3);
`else
        sel_low_d = (state_d == S_WAIT_L);
`endif
        pin6_d = {NUM_PADS{~sel_low_d}};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            shadow_q   <= '0;
            buttons_q  <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            pin6_q     <= '1;
`ifdef GENESIS_6BTN_EN
            six_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            shadow_q   <= shadow_d;
            buttons_q  <= buttons_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            pin6_q     <= pin6_d;
`ifdef GENESIS_6BTN_EN
            six_q      <= six_d;
`endif
        end
    end

    assign bus.pin6     = pin6_q;
    assign bus.buttons  = buttons_q;
    assign bus.pressed  = pressed_q;
    assign bus.released = released_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// Bench for genesis_pad_scanner: behavioural Genesis pad models drive the pins and a
// button-level reference predicts words, edge events, latency and overrun.
module tb_genesis_pad_scanner;
    localparam int NUM_PADS = 2;
    localparam int SETTLE   = 4;
`ifdef GENESIS_6BTN_EN
    localparam int BTN_W    = 12;
    localparam int NPH      = 7;
    localparam int NLOW     = 3;
`else
    localparam int BTN_W    = 8;
    localparam int NPH      = 2;
    localparam int NLOW     = 1;
`endif
    localparam int W   = BTN_W * NUM_PADS;
    localparam int LAT = NPH * SETTLE + 2;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    genesis_pad_scanner_if #(.NUM_PADS(NUM_PADS), .BTN_W(BTN_W)) bus ();

    genesis_pad_scanner #(
        .NUM_PADS(NUM_PADS), .SETTLE_CYCLES(SETTLE), .CNT_W(8)
    ) dut (
        .clk(clk), .clr(clr), .bus(bus)
    );

    // Pad state, bit layout {Mode,X,Y,Z,Start,C,B,A,Right,Left,Down,Up}, 1 = held.
    logic [11:0]         pad_btn [NUM_PADS];
    logic                pad_six [NUM_PADS];
    int                  lows = 0;
    logic                pin6_prev;
    logic [NUM_PADS-1:0] pin0_v, pin1_v, pin2_v, pin3_v, pin5_v, pin8_v;
    logic [W-1:0]        prev_word;
    int                  errors = 0;
    int                  checks = 0;

    // A 6-button pad counts select falls since the scan began; the third low reports its ID.
    always @(negedge clk) begin
        if (bus.frame_tick && bus.en && !bus.busy) lows <= 0;
        else if (pin6_prev === 1'b1 && bus.pin6[0] === 1'b0) lows <= lows + 1;
        pin6_prev <= bus.pin6[0];
    end

    always_comb begin
        pin0_v = '1; pin1_v = '1; pin2_v = '1; pin3_v = '1; pin5_v = '1; pin8_v = '1;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (pad_six[p] && lows == 3) begin
                pin0_v[p] = bus.pin6[p] ? ~pad_btn[p][8]  : 1'b0;
                pin1_v[p] = bus.pin6[p] ? ~pad_btn[p][9]  : 1'b0;
                pin2_v[p] = bus.pin6[p] ? ~pad_btn[p][10] : 1'b0;
                pin3_v[p] = bus.pin6[p] ? ~pad_btn[p][11] : 1'b0;
            end else begin
                pin0_v[p] = ~pad_btn[p][0];
                pin1_v[p] = ~pad_btn[p][1];
                pin2_v[p] = bus.pin6[p] ? ~pad_btn[p][2] : 1'b0;
                pin3_v[p] = bus.pin6[p] ? ~pad_btn[p][3] : 1'b0;
            end
            pin5_v[p] = bus.pin6[p] ? ~pad_btn[p][5] : ~pad_btn[p][4];
            pin8_v[p] = bus.pin6[p] ? ~pad_btn[p][6] : ~pad_btn[p][7];
        end
    end

    assign bus.pin0 = pin0_v;
    assign bus.pin1 = pin1_v;
    assign bus.pin2 = pin2_v;
    assign bus.pin3 = pin3_v;
    assign bus.pin5 = pin5_v;
    assign bus.pin8 = pin8_v;

    // Reference: what a scan should report for the current pad state.
    function automatic logic [W-1:0] expect_word();
        logic [W-1:0] v;
        logic [11:0]  w;
        v = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            w = {4'b0000, pad_btn[p][7:0]};
`ifdef GENESIS_6BTN_EN
            if (pad_six[p]) w[11:8] = pad_btn[p][11:8];
            else if (pad_btn[p][0] && pad_btn[p][1]) w[11:8] = pad_btn[p][3:0];
`endif
            v[p*BTN_W +: BTN_W] = w[BTN_W-1:0];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_scan(output int lat, output int first_low, output int low_cnt,
                           output logic busy_c1, output logic [W-1:0] b,
                           output logic [W-1:0] pr, output logic [W-1:0] rl);
        int cyc;
        lat = -1; first_low = -1; low_cnt = 0; busy_c1 = 1'b0;
        b = '0; pr = '0; rl = '0;
        bus.frame_tick = 1'b1;
        cyc = 0;
        while (cyc < LAT + 20 && lat < 0) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                bus.frame_tick = 1'b0;
                busy_c1 = bus.busy;
            end
            if (bus.pin6 == '0) begin
                low_cnt++;
                if (first_low < 0) first_low = cyc;
            end
            if (bus.valid) begin
                lat = cyc; b = bus.buttons; pr = bus.pressed; rl = bus.released;
            end
        end
    endtask

    task automatic test_reset_state();
        clr = 1'b1; bus.en = 1'b1; bus.frame_tick = 1'b0;
        for (int p = 0; p < NUM_PADS; p++) begin pad_btn[p] = '0; pad_six[p] = 1'b0; end
        repeat (3) tick();
        clr = 1'b0;
        prev_word = '0;
        checks++; if (bus.pin6 !== '1) begin errors++; $display("[TB] FAIL rst_pin6: got %b want all ones", bus.pin6); end
        checks++; if (bus.buttons !== '0 || bus.pressed !== '0 || bus.released !== '0) begin
            errors++; $display("[TB] FAIL rst_words: got %h/%h/%h want 0", bus.buttons, bus.pressed, bus.released); end
        checks++; if ({bus.valid, bus.busy, bus.overrun} !== 3'b000) begin
            errors++; $display("[TB] FAIL rst_flags: got v/b/o=%b want 000", {bus.valid, bus.busy, bus.overrun}); end
    endtask

    task automatic test_reset();
        int valids;
        logic saw_busy;
        pad_btn[0] = 12'h011; pad_btn[1] = 12'h0C0;
        bus.frame_tick = 1'b1; tick(); bus.frame_tick = 1'b0;
        repeat (5) tick();
        checks++; if (bus.pin6 !== '0) begin errors++; $display("[TB] FAIL mid_scan_low: got %b want 00", bus.pin6); end
        clr = 1'b1; repeat (3) tick(); clr = 1'b0;
        prev_word = '0;
        checks++; if (bus.pin6 !== '1 || bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_state: got pin6=%b busy=%b want 11/0", bus.pin6, bus.busy); end
        valids = 0; saw_busy = 1'b0;
        repeat (20) begin
            tick();
            if (bus.valid) valids++;
            if (bus.busy) saw_busy = 1'b1;
        end
        checks++; if (valids != 0 || saw_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_quiet: got valids=%0d busy=%b want 0/0", valids, saw_busy); end
        checks++; if (bus.buttons !== '0) begin errors++; $display("[TB] FAIL abort_buttons: got %h want 0", bus.buttons); end
    endtask

    task automatic test_single_scan();
        int lat, fl, lc;
        logic bc;
        logic [W-1:0] b, pr, rl, exp_w;
        pad_btn[0] = 12'h011; pad_btn[1] = 12'h000;
        exp_w = expect_word();
        do_scan(lat, fl, lc, bc, b, pr, rl);
        checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL single_latency: got %0d want %0d", lat, LAT); end
        checks++; if (b !== exp_w) begin errors++; $display("[TB] FAIL single_buttons: got %h want %h", b, exp_w); end
        checks++; if (pr !== (exp_w & ~prev_word) || rl !== '0) begin
            errors++; $display("[TB] FAIL single_events: got p=%h r=%h want p=%h r=0", pr, rl, exp_w & ~prev_word); end
        checks++; if (fl != SETTLE + 1 || lc != NLOW * SETTLE) begin
            errors++; $display("[TB] FAIL select_phases: got first_low=%0d lows=%0d want %0d/%0d", fl, lc, SETTLE + 1, NLOW * SETTLE); end
        checks++; if (bc !== 1'b1) begin errors++; $display("[TB] FAIL busy_during: got %b want 1", bc); end
        prev_word = exp_w;
        tick();
        checks++; if ({bus.valid, bus.busy} !== 2'b00 || bus.pressed !== '0 || bus.released !== '0) begin
            errors++; $display("[TB] FAIL one_cycle: got v=%b b=%b p=%h r=%h want all 0", bus.valid, bus.busy, bus.pressed, bus.released); end
    endtask

    task automatic test_release();
        int lat, fl, lc;
        logic bc;
        logic [W-1:0] b, pr, rl, exp_w;
        pad_btn[0] = 12'h000;
        exp_w = expect_word();
        do_scan(lat, fl, lc, bc, b, pr, rl);
        checks++; if (lat != LAT || b !== exp_w) begin
            errors++; $display("[TB] FAIL release_buttons: got lat=%0d b=%h want %0d/%h", lat, b, LAT, exp_w); end
        checks++; if (rl !== (~exp_w & prev_word) || pr !== '0) begin
            errors++; $display("[TB] FAIL release_events: got r=%h p=%h want r=%h p=0", rl, pr, ~exp_w & prev_word); end
        prev_word = exp_w;
    endtask

    task automatic test_start_mux();
        int lat, fl, lc;
        logic bc;
        logic [W-1:0] b, pr, rl, exp_w;
        pad_btn[0] = 12'h000; pad_btn[1] = 12'h080;
        exp_w = expect_word();
        do_scan(lat, fl, lc, bc, b, pr, rl);
        checks++; if (b[BTN_W + 7] !== 1'b1 || b[BTN_W + 6] !== 1'b0) begin
            errors++; $display("[TB] FAIL start_vs_c: got start=%b c=%b want 1/0", b[BTN_W + 7], b[BTN_W + 6]); end
        checks++; if (b !== exp_w || pr !== (exp_w & ~prev_word)) begin
            errors++; $display("[TB] FAIL start_word: got b=%h p=%h want %h/%h", b, pr, exp_w, exp_w & ~prev_word); end
        prev_word = exp_w;
    endtask

    task automatic test_overrun();
        int valids, cyc;
        logic [W-1:0] b, exp_w;
        pad_btn[0] = 12'h024; pad_btn[1] = 12'h000;
        exp_w = expect_word();
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_pre: got %b want 0", bus.overrun); end
        valids = 0; b = '0;
        bus.frame_tick = 1'b1;
        for (cyc = 1; cyc <= 3 * LAT; cyc++) begin
            tick();
            bus.frame_tick = (cyc == 3);
            if (bus.valid) begin valids++; b = bus.buttons; end
        end
        checks++; if (valids != 1 || b !== exp_w) begin
            errors++; $display("[TB] FAIL overrun_single: got valids=%0d b=%h want 1/%h", valids, b, exp_w); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b want 1", bus.overrun); end
        prev_word = exp_w;
        clr = 1'b1; tick(); clr = 1'b0;
        prev_word = '0;
        checks++; if (bus.overrun !== 1'b0 || bus.buttons !== '0) begin
            errors++; $display("[TB] FAIL overrun_clr: got o=%b b=%h want 0/0", bus.overrun, bus.buttons); end
    endtask

    task automatic test_en_drop();
        int lat, cyc;
        logic busy_seen;
        logic [W-1:0] b, exp_w;
        pad_btn[0] = 12'($urandom); pad_btn[1] = 12'($urandom);
        exp_w = expect_word();
        lat = -1; b = '0;
        bus.frame_tick = 1'b1;
        for (cyc = 1; cyc <= LAT + 10 && lat < 0; cyc++) begin
            tick();
            bus.frame_tick = 1'b0;
            if (cyc == 2) bus.en = 1'b0;
            if (bus.valid) begin lat = cyc; b = bus.buttons; end
        end
        checks++; if (lat != LAT || b !== exp_w) begin
            errors++; $display("[TB] FAIL en_drop_complete: got lat=%0d b=%h want %0d/%h", lat, b, LAT, exp_w); end
        prev_word = exp_w;
        tick();
        busy_seen = 1'b0;
        bus.frame_tick = 1'b1;
        repeat (LAT + 5) begin
            tick();
            bus.frame_tick = 1'b0;
            if (bus.busy || bus.valid) busy_seen = 1'b1;
        end
        checks++; if (busy_seen !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++; $display("[TB] FAIL en_gate: got activity=%b overrun=%b want 0/0", busy_seen, bus.overrun); end
        bus.en = 1'b1;
    endtask

    task automatic test_commit_overrun();
        int lat, extra, cyc;
        pad_btn[0] = 12'h001; pad_btn[1] = 12'h002;
        lat = -1; extra = 0;
        bus.frame_tick = 1'b1;
        for (cyc = 1; cyc <= 2 * LAT + 5; cyc++) begin
            tick();
            bus.frame_tick = (cyc == LAT - 1);
            if (bus.valid) begin
                if (lat < 0) lat = cyc;
                else extra++;
            end
        end
        checks++; if (lat != LAT || extra != 0) begin
            errors++; $display("[TB] FAIL commit_tick_ignored: got lat=%0d extra=%0d want %0d/0", lat, extra, LAT); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL commit_overrun: got %b want 1", bus.overrun); end
        clr = 1'b1; tick(); clr = 1'b0;
        prev_word = '0;
    endtask

`ifdef GENESIS_6BTN_EN
    task automatic test_six_button();
        int lat, fl, lc;
        logic bc;
        logic [W-1:0] b, pr, rl, exp_w;
        pad_btn[0] = 12'h400; pad_six[0] = 1'b1;
        pad_btn[1] = 12'h024; pad_six[1] = 1'b0;
        exp_w = expect_word();
        do_scan(lat, fl, lc, bc, b, pr, rl);
        checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL six_latency: got %0d want %0d", lat, LAT); end
        checks++; if (b[11:8] !== 4'b0100 || b[23:20] !== 4'b0000) begin
            errors++; $display("[TB] FAIL six_ext: got pad0=%b pad1=%b want 0100/0000", b[11:8], b[23:20]); end
        checks++; if (b !== exp_w) begin errors++; $display("[TB] FAIL six_word: got %h want %h", b, exp_w); end
        prev_word = exp_w;
    endtask
`endif

    task automatic test_random();
        int lat, fl, lc;
        logic bc;
        logic [W-1:0] b, pr, rl, exp_w;
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                pad_btn[p] = 12'($urandom);
`ifdef GENESIS_6BTN_EN
                pad_six[p] = 1'($urandom_range(0, 1));
`else
                pad_six[p] = 1'b0;
`endif
            end
            exp_w = expect_word();
            do_scan(lat, fl, lc, bc, b, pr, rl);
            checks++; if (lat != LAT || b !== exp_w) begin
                errors++; $display("[TB] FAIL rand_buttons[%0d]: got lat=%0d b=%h want %0d/%h", i, lat, b, LAT, exp_w); end
            checks++; if (pr !== (exp_w & ~prev_word) || rl !== (~exp_w & prev_word)) begin
                errors++; $display("[TB] FAIL rand_events[%0d]: got p=%h r=%h want p=%h r=%h", i, pr, rl, exp_w & ~prev_word, ~exp_w & prev_word); end
            prev_word = exp_w;
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset_state();
        test_reset();
        test_single_scan();
        test_release();
        test_start_mux();
        test_overrun();
        test_en_drop();
        test_commit_overrun();
`ifdef GENESIS_6BTN_EN
        test_six_button();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
